// File: rtl/clk_en_pkg.sv
`default_nettype none
//==========================================================================
// clk_en_pkg : shared types, constants and width helpers for clk_en_gen
// Rev 1.0
//==========================================================================
package clk_en_pkg;

   typedef enum logic [0:0] {
      LOCKING = 1'b0,
      LOCKED  = 1'b1
   } lock_state_t;

   localparam int MIN_DIV = 2;

   // Index width for a count of n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // floor(D/2) for any D representable in cnt_w bits fits in cnt_w-1 bits.
   function automatic int half_width(input int cnt_w);
      return (cnt_w > 1) ? (cnt_w - 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/clk_en_gen_if.sv
`default_nettype none
//==========================================================================
// clk_en_gen_if : configuration request/response handshake for clk_en_gen
// Rev 1.0
//==========================================================================
interface clk_en_gen_if
   import clk_en_pkg::*;
#(
   parameter int N_CH  = 2,
   parameter int CNT_W = 16
) ();

   localparam int CH_W = idx_width(N_CH);

   logic              cfg_valid;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch;
   logic [CNT_W-1:0]  cfg_div;
   logic              cfg_en;
   logic              cfg_err;

   modport master (
      output cfg_valid, cfg_ch, cfg_div, cfg_en,
      input  cfg_ready, cfg_err
   );

   modport slave (
      input  cfg_valid, cfg_ch, cfg_div, cfg_en,
      output cfg_ready, cfg_err
   );

endinterface
`default_nettype wire

// File: rtl/clk_en_chan.sv
`default_nettype none
//==========================================================================
// clk_en_chan : one divide-by-D channel producing a strobe and square wave
// Rev 1.0
//==========================================================================
module clk_en_chan
   import clk_en_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 10
) (
   input  wire logic             clk_0,
   input  wire logic             rst_0,
   input  wire logic             load,
   input  wire logic             restart,
   input  wire logic [CNT_W-1:0] div_in,
   input  wire logic             en_in,
   output logic                  ce,
   output logic                  sq
);

   localparam int               HALF_W = half_width(CNT_W);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_DEF  = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0]  div_q, div_d;
   logic              en_q, en_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  last;
   logic [HALF_W-1:0] half;

   assign last = div_q - C_ONE;
   assign half = div_q[CNT_W-1:CNT_W-HALF_W];

   always_comb begin
      div_d = div_q;
      en_d  = en_q;
      cnt_d = cnt_q + C_ONE;
      if (load) begin
         div_d = div_in;
         en_d  = en_in;
         cnt_d = '0;
      end else if (restart || !en_q || (cnt_q == last)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_0) begin
      if (rst_0) begin
         div_q <= C_DEF;
         en_q  <= 1'b1;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         en_q  <= en_d;
         cnt_q <= cnt_d;
      end
   end

   // Outputs are held low throughout reset even though cnt is already 0.
   assign ce = !rst_0 && en_q && (cnt_q == last);
   assign sq = !rst_0 && en_q && (cnt_q < CNT_W'(half));

endmodule
`default_nettype wire

// File: rtl/clk_en_gen.sv
`default_nettype none
//==========================================================================
// clk_en_gen : multi-channel programmable clock-enable generator with lock
// Rev 1.0
//==========================================================================
module clk_en_gen
   import clk_en_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 10,
   parameter int LOCK_CYC    = 16,
   parameter bit ALIGN       = 1'b0
) (
   input  wire logic         clk_0,
   input  wire logic         rst_0,
   clk_en_gen_if.slave       cfg,
   output logic [N_CH-1:0]   ce_out,
   output logic [N_CH-1:0]   sq_out,
   output logic              locked_0
);

   localparam int               CH_W        = idx_width(N_CH);
   localparam int               LK_W        = idx_width(LOCK_CYC);
   localparam logic [CH_W:0]    C_NCH       = (CH_W + 1)'(N_CH);
   localparam logic [LK_W-1:0]  C_LOCK_LAST = LK_W'(LOCK_CYC - 1);
   localparam logic [LK_W-1:0]  C_LK_ONE    = LK_W'(1);
   localparam logic [CNT_W-1:0] C_MIN_DIV   = CNT_W'(MIN_DIV);

   lock_state_t      state_q, state_d;
   logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic             err_q, err_d;
   logic             xfer;
   logic             bad_req;
   logic [N_CH-1:0]  load;
   logic [N_CH-1:0]  restart;

   assign xfer    = cfg.cfg_valid && (state_q == LOCKED);
   assign bad_req = (cfg.cfg_div < C_MIN_DIV) || ({1'b0, cfg.cfg_ch} >= C_NCH);

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      err_d      = 1'b0;
      load       = '0;
      restart    = '0;
      case (state_q)
         LOCKING: begin
            if (lock_cnt_q == C_LOCK_LAST) begin
               state_d = LOCKED;
            end else begin
               lock_cnt_d = lock_cnt_q + C_LK_ONE;
            end
         end
         LOCKED: begin
            if (xfer) begin
               if (bad_req) begin
                  // Rejected requests are consumed without disturbing lock.
                  err_d = 1'b1;
               end else begin
                  state_d    = LOCKING;
                  lock_cnt_d = '0;
                  for (int i = 0; i < N_CH; i++) begin
                     load[i] = (cfg.cfg_ch == CH_W'(i));
                  end
                  restart = ALIGN ? '1 : '0;
               end
            end
         end
         default: state_d = LOCKING;
      endcase
   end

   always_ff @(posedge clk_0) begin
      if (rst_0) begin
         state_q    <= LOCKING;
         lock_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         err_q      <= err_d;
      end
   end

   assign locked_0      = !rst_0 && (state_q == LOCKED);
   assign cfg.cfg_ready = locked_0;
   assign cfg.cfg_err   = !rst_0 && err_q;

   generate
      for (genvar g = 0; g < N_CH; g++) begin : g_chan
         clk_en_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
         ) u_chan (
            .clk_0   (clk_0),
            .rst_0   (rst_0),
            .load    (load[g]),
            .restart (restart[g]),
            .div_in  (cfg.cfg_div),
            .en_in   (cfg.cfg_en),
            .ce      (ce_out[g]),
            .sq      (sq_out[g])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_en_gen.sv
`default_nettype none
//==========================================================================
// tb_clk_en_gen : two DUT flavours (2ch ALIGN=0, 3ch ALIGN=1) vs. period model
// Rev 1.0
//==========================================================================
module tb_clk_en_gen;

   localparam int LOCK = 16;

   logic clk;
   logic rst;

   clk_en_gen_if #(.N_CH(2), .CNT_W(16)) if_a ();
   clk_en_gen_if #(.N_CH(3), .CNT_W(16)) if_b ();

   logic [1:0] ce_a, sq_a;
   logic [2:0] ce_b, sq_b;
   logic       locked_a, locked_b;

   clk_en_gen #(
      .N_CH(2), .CNT_W(16), .DEFAULT_DIV(10), .LOCK_CYC(LOCK), .ALIGN(1'b0)
   ) dut_a (
      .clk_0(clk), .rst_0(rst), .cfg(if_a),
      .ce_out(ce_a), .sq_out(sq_a), .locked_0(locked_a)
   );

   clk_en_gen #(
      .N_CH(3), .CNT_W(16), .DEFAULT_DIV(10), .LOCK_CYC(LOCK), .ALIGN(1'b1)
   ) dut_b (
      .clk_0(clk), .rst_0(rst), .cfg(if_b),
      .ce_out(ce_b), .sq_out(sq_b), .locked_0(locked_b)
   );

   logic v_valid [2];
   int   v_ch    [2];
   int   v_div   [2];
   logic v_en    [2];

   assign if_a.cfg_valid = v_valid[0];
   assign if_a.cfg_ch    = 1'(v_ch[0]);
   assign if_a.cfg_div   = 16'(v_div[0]);
   assign if_a.cfg_en    = v_en[0];
   assign if_b.cfg_valid = v_valid[1];
   assign if_b.cfg_ch    = 2'(v_ch[1]);
   assign if_b.cfg_div   = 16'(v_div[1]);
   assign if_b.cfg_en    = v_en[1];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: each channel is described by its period D, enable and the cycle
   // at which its phase was last zeroed; lock by the cycle lock restarted.
   int   cyc;
   int   m_d      [2][4];
   logic m_en     [2][4];
   int   m_org    [2][4];
   int   m_lorg   [2];
   int   m_errc   [2];
   logic m_acc    [2];
   int   m_acc_cyc[2];

   int   n_cmp = 0;
   int   n_bad = 0;
   logic chk_on;

   function automatic int nch(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         cyc <= 0;
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
               m_d[k][i]   <= 10;
               m_en[k][i]  <= 1'b1;
               m_org[k][i] <= 0;
            end
            m_lorg[k] <= 0;
            m_errc[k] <= -1;
            m_acc[k]  <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            m_acc[k] <= 1'b0;
            if (v_valid[k] && (cyc - m_lorg[k] >= LOCK)) begin
               m_acc[k]     <= 1'b1;
               m_acc_cyc[k] <= cyc;
               if (v_div[k] < 2 || v_ch[k] >= nch(k)) begin
                  m_errc[k] <= cyc + 1;
               end else begin
                  m_d[k][v_ch[k]]  <= v_div[k];
                  m_en[k][v_ch[k]] <= v_en[k];
                  for (int i = 0; i < 4; i++) begin
                     if (k == 1 || i == v_ch[k]) m_org[k][i] <= cyc + 1;
                  end
                  m_lorg[k] <= cyc + 1;
               end
            end
         end
         cyc <= cyc + 1;
      end
   end

   function automatic logic [3:0] exp_vec(input int k, input bit want_sq);
      logic [3:0] r;
      r = '0;
      if (!rst) begin
         for (int i = 0; i < nch(k); i++) begin
            if (m_en[k][i]) begin
               int ph;
               ph = (cyc - m_org[k][i]) % m_d[k][i];
               r[i] = want_sq ? (ph < m_d[k][i] / 2) : (ph == m_d[k][i] - 1);
            end
         end
      end
      return r;
   endfunction

   function automatic logic [3:0] exp_lock(input int k);
      return 4'(!rst && (cyc - m_lorg[k] >= LOCK));
   endfunction

   function automatic logic [3:0] exp_err(input int k);
      return 4'(!rst && (m_errc[k] == cyc));
   endfunction

   function automatic logic [3:0] act_ce(input int k);
      return (k == 0) ? {2'b00, ce_a} : {1'b0, ce_b};
   endfunction

   function automatic logic [3:0] act_sq(input int k);
      return (k == 0) ? {2'b00, sq_a} : {1'b0, sq_b};
   endfunction

   function automatic logic [3:0] act_lock(input int k);
      return 4'((k == 0) ? locked_a : locked_b);
   endfunction

   function automatic logic [3:0] act_rdy(input int k);
      return 4'((k == 0) ? if_a.cfg_ready : if_b.cfg_ready);
   endfunction

   function automatic logic [3:0] act_err(input int k);
      return 4'((k == 0) ? if_a.cfg_err : if_b.cfg_err);
   endfunction

   task automatic chk(input string nm, input int k, input logic [3:0] act,
                      input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h",
                  nm, k, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            chk("ce",     k, act_ce(k),   exp_vec(k, 1'b0));
            chk("sq",     k, act_sq(k),   exp_vec(k, 1'b1));
            chk("locked", k, act_lock(k), exp_lock(k));
            chk("ready",  k, act_rdy(k),  exp_lock(k));
            chk("err",    k, act_err(k),  exp_err(k));
         end
      end
   end

   task automatic wait_to(input int c);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(cyc == c && !rst) && n < 400);
      if (n >= 400) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_cycle actual=timeout required=cycle %0d", c);
      end
   endtask

   task automatic cfg(input int k, input int ch, input int div, input logic en,
                      output int t);
      int n;
      @(posedge clk);
      #1;
      v_valid[k] = 1'b1;
      v_ch[k]    = ch;
      v_div[k]   = div;
      v_en[k]    = en;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!m_acc[k] && n < 64);
      v_valid[k] = 1'b0;
      t = -1;
      if (m_acc[k]) begin
         t = m_acc_cyc[k];
      end else begin
         n_cmp++;
         n_bad++;
         $display("FAIL cfg_accept dut%0d actual=no transfer required=transfer", k);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      logic [4:0] pat;
      rst    = 1'b1;
      chk_on = 1'b0;
      for (int k = 0; k < 2; k++) begin
         v_valid[k] = 1'b0;
         v_ch[k]    = 0;
         v_div[k]   = 10;
         v_en[k]    = 1'b1;
      end
      @(posedge clk);
      #1 chk_on = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Defaults: D=10 on every channel, lock after 16 cycles.
      wait_to(4);  chk("lit_sq_c4",   0, {2'b00, sq_a}, 4'b0011);
      wait_to(5);  chk("lit_sq_c5",   0, {2'b00, sq_a}, 4'b0000);
      wait_to(9);  chk("lit_ce_c9",   0, {2'b00, ce_a}, 4'b0011);
      wait_to(15); chk("lit_lock_15", 0, 4'(locked_a),  4'b0000);
      wait_to(16); chk("lit_lock_16", 0, 4'(locked_a),  4'b0001);
                   chk("lit_rdy_16",  1, 4'(if_b.cfg_ready), 4'b0001);
      wait_to(19); chk("lit_ce_c19",  0, {2'b00, ce_a}, 4'b0011);
      wait_to(29); chk("lit_ce_c29",  0, {2'b00, ce_a}, 4'b0011);

      // Independent channel restart: ch1 -> D=4.
      cfg(0, 1, 4, 1'b1, t);
      wait_to(t + 3);  chk("lit_a_ce1_t3",   0, 4'(ce_a[1]), 4'b0000);
      wait_to(t + 4);  chk("lit_a_ce1_t4",   0, 4'(ce_a[1]), 4'b0001);
      wait_to(t + 8);  chk("lit_a_ce1_t8",   0, 4'(ce_a[1]), 4'b0001);
      wait_to(t + 16); chk("lit_a_lock_t16", 0, 4'(locked_a), 4'b0000);
      wait_to(t + 17); chk("lit_a_lock_t17", 0, 4'(locked_a), 4'b0001);

      // Aligned restart: ch1 -> D=4 also restarts ch0 and ch2.
      cfg(1, 1, 4, 1'b1, t);
      wait_to(t + 4);  chk("lit_b_ce_t4",  1, {1'b0, ce_b}, 4'b0010);
      wait_to(t + 10); chk("lit_b_ce_t10", 1, {1'b0, ce_b}, 4'b0101);

      // Odd divide: D=5 on ch0 gives 1,1,0,0,0.
      cfg(0, 0, 5, 1'b1, t);
      pat = 5'b00011;
      for (int j = 1; j <= 5; j++) begin
         wait_to(t + j);
         chk("lit_a_sq0_d5", 0, 4'(sq_a[0]), 4'(pat[j-1]));
      end
      chk("lit_a_ce0_d5", 0, 4'(ce_a[0]), 4'b0001);

      // Rejections: divide below 2, and an out-of-range channel.
      cfg(1, 0, 1, 1'b1, t);
      wait_to(t + 1); chk("lit_b_err_div", 1, 4'(if_b.cfg_err), 4'b0001);
                      chk("lit_b_lock_div", 1, 4'(locked_b),   4'b0001);
      wait_to(t + 2); chk("lit_b_err_off", 1, 4'(if_b.cfg_err), 4'b0000);
      cfg(1, 3, 6, 1'b1, t);
      wait_to(t + 1); chk("lit_b_err_ch", 1, 4'(if_b.cfg_err), 4'b0001);
      cfg(0, 1, 0, 1'b1, t);
      wait_to(t + 1); chk("lit_a_err_div0", 0, 4'(if_a.cfg_err), 4'b0001);

      // Disable ch1.
      cfg(0, 1, 7, 1'b0, t);
      wait_to(t + 1); chk("lit_a_dis_sq1", 0, 4'(sq_a[1]), 4'b0000);
      wait_to(t + 7); chk("lit_a_dis_ce1", 0, 4'(ce_a[1]), 4'b0000);

      // Reset pulse at lock count 8 while relocking.
      cfg(0, 0, 6, 1'b1, t);
      wait_to(t + 8);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("lit_rst_lock", 0, 4'(locked_a),    4'b0000);
      chk("lit_rst_sq",   0, {2'b00, sq_a},   4'b0000);
      chk("lit_rst_sqb",  1, {1'b0, sq_b},    4'b0000);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_to(3);  chk("lit_post_sq_c3",  0, {2'b00, sq_a}, 4'b0011);
      wait_to(9);  chk("lit_post_ce_c9",  0, {2'b00, ce_a}, 4'b0011);
      wait_to(15); chk("lit_post_lock15", 0, 4'(locked_a),  4'b0000);
      wait_to(16); chk("lit_post_lock16", 0, 4'(locked_a),  4'b0001);
      wait_to(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
